gshare_bp_param: RTL and testbench
==================================

Name: gshare_bp_param

Overview:
- Parametrised next-generation gshare direction predictor for the in-order fetch front-end.
- Hashes the PC with a Global History Register (GHR) to index a Pattern History Table (PHT) of N-bit saturating counters.
- Adds a registered prediction output and same-cycle train→predict bypass.
- Adds a runtime gshare/bimodal mode select, a sequential PHT initialisation/flush sweep, and saturating performance counters.

Parameters:
- PC_W, 7, predict/train PC width; must be >= IDX_W.
- HIST_W, 7, GHR width; must be >= 2.
- IDX_W, 7, PHT index width; PHT depth = 2^IDX_W.
- CTR_W, 2, saturating counter width; must be >= 2.
- CTR_INIT, 1, counter value written at init/flush (weak not-taken for CTR_W=2).
- STAT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0=gshare index, 1=bimodal index (history ignored)
- flush  in  1  one-cycle pulse; re-initialises PHT, GHR and statistics
- ready  out  1  1 when in RUN; predictions and training accepted only when 1
- pred_valid  in  1  prediction request
- pred_pc  in  PC_W  PC of the branch to predict
- pred_out_valid  out  1  registered result valid
- pred_taken  out  1  registered direction prediction
- pred_history  out  HIST_W  GHR snapshot used for this prediction; pipelined with the branch
- train_valid  in  1  resolved-branch update
- train_pc  in  PC_W  PC of the resolved branch
- train_history  in  HIST_W  history snapshot returned with the resolved branch
- train_taken  in  1  actual direction
- train_mispredicted  in  1  prediction was wrong
- stat_predictions  out  STAT_W  accepted predictions since reset/flush
- stat_mispredicts  out  STAT_W  accepted mispredict reports since reset/flush

Behaviour:
- Reset (async): FSM=INIT, init pointer=0, GHR=0, ready=0, pred_out_valid=0, pred_taken=0, pred_history=0, both stats=0. PHT contents are not reset directly; the INIT sweep writes them.
- INIT state: writes CTR_INIT to PHT[ptr] each cycle, ptr++. After the write of entry 2^IDX_W-1, FSM=RUN and ready=1 on the next cycle. Exactly 2^IDX_W cycles in INIT. pred_valid and train_valid are ignored in INIT.
- flush: from RUN or INIT, go to INIT with ptr=0, GHR=0, stats=0, pred_out_valid=0 next cycle. A flush during INIT restarts the sweep.
- Index computation: h = low IDX_W bits of history, zero-extended if HIST_W < IDX_W.
  - gshare: idx = pc[IDX_W-1:0] ^ h.
  - bimodal: idx = pc[IDX_W-1:0].
  - The same rule applies to prediction (using the current GHR) and training (using train_history). mode is sampled each cycle; the team guarantees it changes only around a flush.
- Prediction (RUN, pred_valid=1):
  - Latency 1 cycle.
  - Next cycle: pred_out_valid=1, pred_taken = MSB of PHT[idx], pred_history = GHR value at the request cycle.
  - If pred_valid=0, pred_out_valid=0 next cycle; pred_taken and pred_history hold.
- Bypass: if a training write in the same cycle targets the same idx, the prediction uses the post-update counter value.
- GHR update priority, highest first:
  1. flush → 0.
  2. train_valid & train_mispredicted → {train_history[HIST_W-2:0], train_taken}.
  3. pred_valid → {GHR[HIST_W-2:0], predicted bit}, where the predicted bit includes bypass.
  4. Otherwise hold.
  - A prediction issued in a restore cycle still produces pred_out_valid=1, using the pre-restore GHR.
- PHT training (RUN, train_valid=1):
  - Taken: counter+1, saturating at 2^CTR_W-1.
  - Not-taken: counter-1, saturating at 0.
  - One write per cycle. train_mispredicted does not alter the counter update.
- Statistics:
  - stat_predictions +1 per accepted prediction; stat_mispredicts +1 per train_valid & train_mispredicted in RUN.
  - Both saturate at 2^STAT_W-1; no wrap.

Test Plan:
- Reset release with defaults → ready=0 for exactly 128 cycles, then 1; first prediction to any PC → pred_taken=0 (CTR_INIT=1).
- Gshare counters: GHR=0, train pc=5 taken ×2 → counter 3; pred pc=5 → pred_taken=1 next cycle, GHR becomes 0000001. Four not-taken trains → counter 0 (saturates), pred_taken=0.
- Same-cycle bypass: counter at idx 9 = 1; train taken idx 9 together with pred idx 9 → pred_taken=1, counter=2.
- Mispredict restore priority: GHR=0x2A; same cycle pred_valid=1 plus train mispredicted with train_history=0x11, taken=1 → GHR=0x23; pred_history output=0x2A; stat_mispredicts=1.
- Flush mid-operation: flush at cycle 10 of RUN → ready=0 next cycle, stats=0, GHR=0; flush again at INIT cycle 50 → 128 further cycles before ready=1.
- Bimodal mode and stat saturation (STAT_W=3): mode=1, GHR nonzero, predict pc=3 twice → same counter used; 9 predictions → stat_predictions=7.

Source files
------------

// File: rtl/gshare_bp_param.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_bp_param
//  Purpose  : Parametrised gshare / bimodal branch direction predictor.
//             The PC is hashed with the global history register (GHR) to
//             index a pattern history table (PHT) of CTR_W-bit saturating
//             counters. The prediction is registered (1-cycle latency). A
//             training write in the same cycle to the same entry is bypassed
//             into the prediction. A sequential sweep initialises the PHT
//             after reset or flush. Saturating statistics counters are
//             included.
//  Ports    : clk, rst_n (async, active-low)
//             mode               0 = gshare index, 1 = bimodal index
//             flush              re-initialise PHT, GHR and statistics
//             ready              high while in RUN
//             pred_valid/pred_pc               prediction request
//             pred_out_valid/pred_taken/pred_history  registered result
//             train_valid/train_pc/train_history/train_taken/
//             train_mispredicted               resolved-branch update
//             stat_predictions/stat_mispredicts  saturating counters
//  Revision : 1.0 - initial release
// ============================================================================
module gshare_bp_param #(
    parameter int PC_W     = 7,
    parameter int HIST_W   = 7,
    parameter int IDX_W    = 7,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 1,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              flush,
    output logic              ready,
    input  logic              pred_valid,
    input  logic [PC_W-1:0]   pred_pc,
    output logic              pred_out_valid,
    output logic              pred_taken,
    output logic [HIST_W-1:0] pred_history,
    input  logic              train_valid,
    input  logic [PC_W-1:0]   train_pc,
    input  logic [HIST_W-1:0] train_history,
    input  logic              train_taken,
    input  logic              train_mispredicted,
    output logic [STAT_W-1:0] stat_predictions,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int               c_depth    = 1 << IDX_W;
    localparam logic [CTR_W-1:0]  c_ctr_max  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0]  c_ctr_zero = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0]  c_ctr_one  = {{(CTR_W-1){1'b0}}, 1'b1};
    localparam logic [CTR_W-1:0]  c_ctr_init = CTR_INIT[CTR_W-1:0];
    localparam logic [IDX_W-1:0]  c_idx_last = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0]  c_idx_one  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] c_stat_max = {STAT_W{1'b1}};
    localparam logic [STAT_W-1:0] c_stat_one = {{(STAT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [CTR_W-1:0]  r_pht [c_depth];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic              w_init_wr;
    logic [HIST_W-1:0] r_ghr;
    logic              r_pred_out_valid;
    logic              r_pred_taken;
    logic [HIST_W-1:0] r_pred_history;
    logic [STAT_W-1:0] r_stat_pred;
    logic [STAT_W-1:0] r_stat_misp;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic              w_run;
    logic              w_pred_acc;
    logic              w_train_acc;
    logic [IDX_W-1:0]  w_pred_h;
    logic [IDX_W-1:0]  w_train_h;
    logic [IDX_W-1:0]  w_pred_idx;
    logic [IDX_W-1:0]  w_train_idx;
    logic [CTR_W-1:0]  w_train_ctr;
    logic [CTR_W-1:0]  w_train_new;
    logic [CTR_W-1:0]  w_pred_ctr;
    logic              w_bypass;
    logic              w_pred_bit;

    // PC bits above the index width do not take part in hashing.
    logic              w_unused_pc_bits;
    assign w_unused_pc_bits = ^{pred_pc, train_pc};

    assign w_run       = (r_state == ST_RUN);
    assign w_pred_acc  = w_run & pred_valid  & ~flush;
    assign w_train_acc = w_run & train_valid & ~flush;

    // History folded to index width: truncate when wider, zero-extend
    // when narrower.
    generate
        if (HIST_W >= IDX_W) begin : g_hist_trunc
            assign w_pred_h  = r_ghr[IDX_W-1:0];
            assign w_train_h = train_history[IDX_W-1:0];
        end else begin : g_hist_zext
            assign w_pred_h  = {{(IDX_W-HIST_W){1'b0}}, r_ghr};
            assign w_train_h = {{(IDX_W-HIST_W){1'b0}}, train_history};
        end
    endgenerate

    assign w_pred_idx  = mode ? pred_pc[IDX_W-1:0]
                              : (pred_pc[IDX_W-1:0] ^ w_pred_h);
    assign w_train_idx = mode ? train_pc[IDX_W-1:0]
                              : (train_pc[IDX_W-1:0] ^ w_train_h);

    assign w_train_ctr = r_pht[w_train_idx];

    always_comb begin
        w_train_new = w_train_ctr;
        if (train_taken) begin
            if (w_train_ctr != c_ctr_max) begin
                w_train_new = w_train_ctr + c_ctr_one;
            end
        end else begin
            if (w_train_ctr != c_ctr_zero) begin
                w_train_new = w_train_ctr - c_ctr_one;
            end
        end
    end

    // A training write landing on the entry being predicted this cycle is
    // forwarded so the prediction sees the post-update counter.
    assign w_bypass   = w_train_acc & (w_train_idx == w_pred_idx);
    assign w_pred_ctr = w_bypass ? w_train_new : r_pht[w_pred_idx];
    assign w_pred_bit = w_pred_ctr[CTR_W-1];

    // ------------------------------------------------------------------
    // Init / run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_init_wr   = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_wr = 1'b1;
                w_ptr_nxt = r_ptr + c_idx_one;
                if (r_ptr == c_idx_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_ptr_nxt   = '0;
            end
        endcase
        // Flush restarts the sweep from entry 0, whatever the state.
        if (flush) begin
            w_state_nxt = ST_INIT;
            w_ptr_nxt   = '0;
            w_init_wr   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // PHT write port (one write per cycle; init sweep or training)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_pht[r_ptr] <= c_ctr_init;
        end else if (w_train_acc) begin
            r_pht[w_train_idx] <= w_train_new;
        end
    end

    // ------------------------------------------------------------------
    // Global history register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (flush) begin
            r_ghr <= '0;
        end else if (w_train_acc && train_mispredicted) begin
            // Restore from the resolved branch's snapshot plus its outcome.
            r_ghr <= {train_history[HIST_W-2:0], train_taken};
        end else if (w_pred_acc) begin
            r_ghr <= {r_ghr[HIST_W-2:0], w_pred_bit};
        end
    end

    // ------------------------------------------------------------------
    // Registered prediction output
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_out_valid <= 1'b0;
            r_pred_taken     <= 1'b0;
            r_pred_history   <= '0;
        end else begin
            r_pred_out_valid <= w_pred_acc;
            if (w_pred_acc) begin
                r_pred_taken   <= w_pred_bit;
                r_pred_history <= r_ghr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_pred <= '0;
            r_stat_misp <= '0;
        end else if (flush) begin
            r_stat_pred <= '0;
            r_stat_misp <= '0;
        end else begin
            if (w_pred_acc && (r_stat_pred != c_stat_max)) begin
                r_stat_pred <= r_stat_pred + c_stat_one;
            end
            if (w_train_acc && train_mispredicted &&
                (r_stat_misp != c_stat_max)) begin
                r_stat_misp <= r_stat_misp + c_stat_one;
            end
        end
    end

    assign ready            = w_run;
    assign pred_out_valid   = r_pred_out_valid;
    assign pred_taken       = r_pred_taken;
    assign pred_history     = r_pred_history;
    assign stat_predictions = r_stat_pred;
    assign stat_mispredicts = r_stat_misp;

endmodule
`default_nettype wire

// File: tb/tb_gshare_bp_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gshare_bp_param
//  Purpose  : Self-checking bench for gshare_bp_param (default widths,
//             STAT_W=3 so statistic saturation is reachable).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gshare_bp_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic       flush;
    logic       ready;
    logic       pred_valid;
    logic [6:0] pred_pc;
    logic       pred_out_valid;
    logic       pred_taken;
    logic [6:0] pred_history;
    logic       train_valid;
    logic [6:0] train_pc;
    logic [6:0] train_history;
    logic       train_taken;
    logic       train_mispredicted;
    logic [2:0] stat_predictions;
    logic [2:0] stat_mispredicts;

    always #5 clk = ~clk;

    gshare_bp_param #(
        .PC_W(7), .HIST_W(7), .IDX_W(7), .CTR_W(2), .CTR_INIT(1), .STAT_W(3)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mode               (mode),
        .flush              (flush),
        .ready              (ready),
        .pred_valid         (pred_valid),
        .pred_pc            (pred_pc),
        .pred_out_valid     (pred_out_valid),
        .pred_taken         (pred_taken),
        .pred_history       (pred_history),
        .train_valid        (train_valid),
        .train_pc           (train_pc),
        .train_history      (train_history),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .stat_predictions   (stat_predictions),
        .stat_mispredicts   (stat_mispredicts)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_pht [128];
    logic [6:0] m_ghr;
    bit         m_run;
    int         m_ptr;
    int         m_sp;
    int         m_sm;
    bit         m_pov;
    logic [7:0] sb_q [$];   // {expected taken, expected history}

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_upd(input int c, input logic t);
        if (t) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_ptr = 0; m_ghr = '0;
        m_sp = 0; m_sm = 0; m_pov = 1'b0;
        sb_q.delete();
    endtask

    // One clock: predict from pre-edge state, advance, then check.
    task automatic tick();
        bit   pacc, tacc, pbit;
        int   pidx, tidx, tnew, pctr;
        logic [7:0] e;
        pacc = rst_n && m_run && pred_valid  && !flush;
        tacc = rst_n && m_run && train_valid && !flush;
        pidx = mode ? int'(pred_pc)  : int'(pred_pc ^ m_ghr);
        tidx = mode ? int'(train_pc) : int'(train_pc ^ train_history);
        tnew = sat_upd(m_pht[tidx], train_taken);
        pctr = (tacc && tidx == pidx) ? tnew : m_pht[pidx];
        pbit = (pctr >= 2);
        if (pacc) sb_q.push_back({pbit, m_ghr});
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            m_run = 1'b0; m_ptr = 0; m_ghr = '0;
            m_sp = 0; m_sm = 0; m_pov = 1'b0;
        end else if (!m_run) begin
            m_pht[m_ptr] = 1;
            if (m_ptr == 127) m_run = 1'b1;
            m_ptr = (m_ptr + 1) % 128;
            m_pov = 1'b0;
        end else begin
            if (tacc) m_pht[tidx] = tnew;
            if (tacc && train_mispredicted)
                m_ghr = {train_history[5:0], train_taken};
            else if (pacc)
                m_ghr = {m_ghr[5:0], pbit};
            if (pacc && m_sp < 7) m_sp++;
            if (tacc && train_mispredicted && m_sm < 7) m_sm++;
            m_pov = pacc;
        end
        chk("ready", ready, m_run);
        chk("pred_out_valid", pred_out_valid, m_pov);
        if (m_pov && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_taken", pred_taken, e[7]);
            chk("sb_history", pred_history, e[6:0]);
        end
        chk("stat_predictions", stat_predictions, m_sp);
        chk("stat_mispredicts", stat_mispredicts, m_sm);
    endtask

    task automatic predict(input logic [6:0] pc);
        pred_valid = 1'b1; pred_pc = pc;
        tick();
        pred_valid = 1'b0;
    endtask

    task automatic train(input logic [6:0] pc, input logic [6:0] hist,
                         input logic tk, input logic misp);
        train_valid = 1'b1; train_pc = pc; train_history = hist;
        train_taken = tk; train_mispredicted = misp;
        tick();
        train_valid = 1'b0; train_mispredicted = 1'b0;
    endtask

    // Counts not-ready cycles (bounded) and checks the sweep length.
    task automatic wait_ready(input string tag);
        int cnt;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 300) begin
            cnt++;
            tick();
        end
        chk(tag, cnt, 128);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; flush = 1'b0;
        pred_valid = 1'b0; pred_pc = '0;
        train_valid = 1'b0; train_pc = '0; train_history = '0;
        train_taken = 1'b0; train_mispredicted = 1'b0;
        for (int i = 0; i < 128; i++) m_pht[i] = 0;
        model_reset();
        tick();
        tick();

        // Reset state
        chk("rst_ready", ready, 0);
        chk("rst_pred_out_valid", pred_out_valid, 0);
        chk("rst_pred_taken", pred_taken, 0);
        chk("rst_pred_history", pred_history, 0);
        chk("rst_stat_pred", stat_predictions, 0);
        chk("rst_stat_misp", stat_mispredicts, 0);

        rst_n = 1'b1;
        wait_ready("init_len_reset");

        // Fresh table: weak not-taken everywhere
        predict(7'h11);
        chk("first_pred_taken", pred_taken, 0);

        // Gshare counter training at idx 5 (GHR=0)
        train(7'd5, 7'd0, 1'b1, 1'b0);
        train(7'd5, 7'd0, 1'b1, 1'b0);
        predict(7'd5);
        chk("trained_taken", pred_taken, 1);
        chk("trained_hist", pred_history, 0);
        repeat (4) train(7'd5, 7'd0, 1'b0, 1'b0);
        predict(7'd4);  // GHR=1 -> idx 5
        chk("sat_low_taken", pred_taken, 0);
        chk("ghr_after_taken", pred_history, 7'h01);

        // Same-cycle bypass at idx 9 (GHR=2, pc 11 -> idx 9)
        pred_valid = 1'b1; pred_pc = 7'd11;
        train_valid = 1'b1; train_pc = 7'd9; train_history = 7'd0;
        train_taken = 1'b1; train_mispredicted = 1'b0;
        tick();
        pred_valid = 1'b0; train_valid = 1'b0;
        chk("bypass_taken", pred_taken, 1);
        predict(7'd12);  // GHR=5 -> idx 9, counter now 2
        chk("bypass_ctr2", pred_taken, 1);

        // Mispredict restore priority
        train(7'd0, 7'h15, 1'b0, 1'b1);  // GHR <- 0x2A
        pred_valid = 1'b1; pred_pc = 7'h30;
        train_valid = 1'b1; train_pc = 7'h40; train_history = 7'h11;
        train_taken = 1'b1; train_mispredicted = 1'b1;
        tick();
        pred_valid = 1'b0; train_valid = 1'b0; train_mispredicted = 1'b0;
        chk("restore_pred_hist", pred_history, 7'h2A);
        chk("restore_stat_misp", stat_mispredicts, 2);
        predict(7'd0);
        chk("restored_ghr", pred_history, 7'h23);
        chk("stat_pred_sat_gshare", stat_predictions, 7);

        // Flush in RUN, then again mid-sweep; requests during INIT ignored
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", ready, 0);
        chk("flush_stat_pred", stat_predictions, 0);
        chk("flush_stat_misp", stat_mispredicts, 0);
        pred_valid = 1'b1; pred_pc = 7'd5;
        train_valid = 1'b1; train_pc = 7'd5; train_taken = 1'b1;
        train_mispredicted = 1'b1;
        repeat (49) tick();
        pred_valid = 1'b0; train_valid = 1'b0; train_mispredicted = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_ready("init_len_reflush");
        predict(7'd9);  // GHR=0 after flush, idx 9 reinitialised
        chk("post_flush_taken", pred_taken, 0);
        chk("post_flush_hist", pred_history, 0);

        // Bimodal mode with nonzero GHR, stat saturation
        mode = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_ready("init_len_bimodal");
        train(7'h7F, 7'h15, 1'b0, 1'b1);  // GHR <- 0x2A
        train(7'd3, 7'h15, 1'b1, 1'b0);
        train(7'd3, 7'h2A, 1'b1, 1'b0);
        predict(7'd3);
        chk("bimodal_taken0", pred_taken, 1);
        chk("bimodal_hist0", pred_history, 7'h2A);
        predict(7'd3);
        chk("bimodal_taken1", pred_taken, 1);
        for (int i = 0; i < 7; i++) predict(7'(i + 20));
        chk("stat_pred_sat", stat_predictions, 7);
        chk("stat_misp_bimodal", stat_mispredicts, 1);
        tick();
        chk("idle_pov", pred_out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
